// File: rtl/fib_pkg.sv
// Shared types and helpers for the Fibonacci rate-splitting datapath.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package fib_pkg;

    localparam int FIB_W = 16;

    typedef struct packed {
        logic [FIB_W-1:0] num;
        logic [FIB_W-1:0] num2;
    } fib_pair_t;

    // Pointer width for a pair FIFO of the given depth (at least one bit).
    function automatic int pair_ptr_w(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/fib_pair_fifo.sv
// Pair FIFO: stores {num,num2} pairs, exposes the head pair combinationally.
// Latency: a pair pushed at edge N is visible at the head after edge N when the FIFO was empty.
// Backpressure: push is ignored when full, pop is ignored when empty; full/empty depend only on state.
module fib_pair_fifo
    import fib_pkg::*;
#(
    parameter int W     = FIB_W,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         push,
    input  logic [W-1:0] push_num,
    input  logic [W-1:0] push_num2,
    input  logic         pop,
    output logic [W-1:0] head_num,
    output logic [W-1:0] head_num2,
    output logic         full,
    output logic         empty
);

    localparam int PW = pair_ptr_w(DEPTH);
    localparam int CW = $clog2(DEPTH + 1);

    logic [W-1:0]  num_mem  [DEPTH];
    logic [W-1:0]  num2_mem [DEPTH];
    logic [PW-1:0] wr_ptr;
    logic [PW-1:0] rd_ptr;
    logic [CW-1:0] count;
    logic          do_push;
    logic          do_pop;

    assign full      = (count == CW'(DEPTH));
    assign empty     = (count == '0);
    assign do_push   = push && !full;
    assign do_pop    = pop && !empty;
    assign head_num  = num_mem[rd_ptr];
    assign head_num2 = num2_mem[rd_ptr];

    // Pair storage; cleared on reset so the head reads as zero while empty.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int i = 0; i < DEPTH; i++) begin
                num_mem[i]  <= '0;
                num2_mem[i] <= '0;
            end
        end else if (do_push) begin
            num_mem[wr_ptr]  <= push_num;
            num2_mem[wr_ptr] <= push_num2;
        end
    end

    // Pointers wrap naturally (DEPTH is a power of two); count tracks occupancy 0..DEPTH.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr <= wr_ptr + PW'(1);
            end
            if (do_pop) begin
                rd_ptr <= rd_ptr + PW'(1);
            end
            if (do_push && !do_pop) begin
                count <= count + CW'(1);
            end else if (!do_push && do_pop) begin
                count <= count - CW'(1);
            end
        end
    end

endmodule

// File: rtl/fib_rate_splitter.sv
// Splits double-rate {num,num2} pairs into a single-rate word stream, num first; FIB_RATE_CHECK_EN adds a recurrence checker.
// Latency: pair accepted at edge N shows num after edge N and num2 after edge N+1 when down_ready stays high.
// Backpressure: up_ready = !full from registered state only; stalls hold down_data and the half-select.
module fib_rate_splitter
    import fib_pkg::*;
#(
    parameter int W     = FIB_W,
    parameter int DEPTH = 2
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic         up_valid,
    output logic         up_ready,
    input  logic [W-1:0] up_num,
    input  logic [W-1:0] up_num2,
    output logic         down_valid,
    input  logic         down_ready,
    output logic [W-1:0] down_data
`ifdef FIB_RATE_CHECK_EN
    ,
    output logic         fib_err
`endif
);

    logic         sel;
    logic         full;
    logic         empty;
    logic         word_hs;
    logic         pair_pop;
    logic [W-1:0] head_num;
    logic [W-1:0] head_num2;

    assign up_ready   = !full;
    assign down_valid = !empty;
    assign down_data  = sel ? head_num2 : head_num;
    assign word_hs    = down_valid && down_ready;
    // The head pair is released only once its second word has been taken.
    assign pair_pop   = word_hs && sel;

    fib_pair_fifo #(
        .W     (W),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (up_valid && up_ready),
        .push_num  (up_num),
        .push_num2 (up_num2),
        .pop       (pair_pop),
        .head_num  (head_num),
        .head_num2 (head_num2),
        .full      (full),
        .empty     (empty)
    );

    // Half-select: advances num -> num2 -> next pair on each accepted word.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sel <= 1'b0;
        end else if (word_hs) begin
            sel <= !sel;
        end
    end

`ifdef FIB_RATE_CHECK_EN
    logic [W-1:0] p1;
    logic [W-1:0] p2;
    logic [1:0]   seed_cnt;

    // Recurrence checker: first two accepted words seed history, later words must equal p1+p2.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            p1       <= '0;
            p2       <= '0;
            seed_cnt <= 2'd0;
            fib_err  <= 1'b0;
        end else if (word_hs) begin
            if (seed_cnt != 2'd2) begin
                seed_cnt <= seed_cnt + 2'd1;
            end else if (down_data != W'(p1 + p2)) begin
                fib_err <= 1'b1;
            end
            p2 <= p1;
            p1 <= down_data;
        end
    end
`endif

endmodule
